// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and a pointer-step check.
// Pointers are carried in a fixed-width container (ptr_t). Each block
// zero-extends into it and size-casts back to its own PTR_WIDTH+1 bits.
package fifo_pkg;

    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Gray -> binary over the low w bits. Bits above w must be zero.
    function automatic ptr_t gray2bin(input ptr_t g, input int w);
        ptr_t b;
        logic acc;
        b   = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

    // Binary -> Gray. Bits above the pointer width must be zero.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // A legal Gray pointer update changes at most one bit.
    function automatic logic gray_step_ok(input ptr_t a, input ptr_t b);
        ptr_t d;
        int   cnt;
        d   = a ^ b;
        cnt = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            cnt += int'(d[i]);
        end
        return (cnt <= 1);
    endfunction

endpackage

// File: rtl/rptr_wsync_decoder_sync_chain.sv
// Multi-flop synchronizer. It has no logic between stages, and every flop resets to 0.
module sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg_q;
    logic [STAGES-1:0][WIDTH-1:0] stg_d;

    // Next-stage wiring: stage 0 takes the async input, and each later stage takes its predecessor.
    always_comb begin
        stg_d    = '0;
        stg_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    // Chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/rptr_wsync_decoder.sv
// Write-domain receiver for the Gray read pointer. It synchronizes the pointer,
// decodes it to binary, and derives the fill level, almost-full, and sticky
// overflow and pointer-integrity flags.
module rptr_wsync_decoder
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic [PTR_WIDTH:0] g_rptr,
    input  logic [PTR_WIDTH:0] b_wptr,
    input  logic               w_en,
    input  logic               full,
    input  logic               clr_sticky,
    output logic [PTR_WIDTH:0] g_rptr_sync,
    output logic [PTR_WIDTH:0] b_rptr_sync,
    output logic [PTR_WIDTH:0] wr_level,
    output logic               almost_full,
    output logic               overflow,
    output logic               sync_err
);

    localparam int PW    = PTR_WIDTH + 1;
    localparam int DEPTH = 1 << PTR_WIDTH;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("AFULL_THRESH must be in 1..DEPTH");
    end

    logic [PW-1:0] g_sync;

    sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (g_rptr),
        .q     (g_sync)
    );

    logic [PW-1:0] g_prev_q, g_prev_d;
    logic [PW-1:0] b_rptr_q, b_rptr_d;
    logic [PW-1:0] wr_level_q, wr_level_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;
    logic          sync_err_q, sync_err_d;
    logic          err_hit;

    // Decode, level subtract and flag next-state. The level uses the registered
    // read pointer, so it lags reads and can only overstate the fill.
    always_comb begin
        g_prev_d      = g_sync;
        b_rptr_d      = PW'(gray2bin(ptr_t'(g_sync), PW));
        wr_level_d    = b_wptr - b_rptr_q;
        almost_full_d = (int'(wr_level_d) >= AFULL_THRESH);

        // A set and a clear on the same edge leave the flag set.
        overflow_d = overflow_q;
        if (clr_sticky)    overflow_d = 1'b0;
        if (w_en && full)  overflow_d = 1'b1;

        // A multi-bit jump between successive synced samples means the Gray
        // source misbehaved. A level beyond DEPTH means the pointers disagree.
        err_hit    = !gray_step_ok(ptr_t'(g_sync), ptr_t'(g_prev_q))
                     || (int'(wr_level_d) > DEPTH);
        sync_err_d = sync_err_q;
        if (clr_sticky) sync_err_d = 1'b0;
        if (err_hit)    sync_err_d = 1'b1;
    end

    // Output and history registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            g_prev_q      <= '0;
            b_rptr_q      <= '0;
            wr_level_q    <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            g_prev_q      <= g_prev_d;
            b_rptr_q      <= b_rptr_d;
            wr_level_q    <= wr_level_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign g_rptr_sync = g_sync;
    assign b_rptr_sync = b_rptr_q;
    assign wr_level    = wr_level_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_rptr_wsync_decoder.sv
// Directed bench for rptr_wsync_decoder. Stimulus pushes the expected values,
// each tagged with the cycle it applies to. A negedge monitor pops and checks them.
module tb_rptr_wsync_decoder;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [3:0] g_rptr, b_wptr;
    logic       w_en, full, clr_sticky;
    logic [3:0] g_rptr_sync, b_rptr_sync, wr_level;
    logic       almost_full, overflow, sync_err;

    rptr_wsync_decoder #(
        .PTR_WIDTH    (3),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (6)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .g_rptr      (g_rptr),
        .b_wptr      (b_wptr),
        .w_en        (w_en),
        .full        (full),
        .clr_sticky  (clr_sticky),
        .g_rptr_sync (g_rptr_sync),
        .b_rptr_sync (b_rptr_sync),
        .wr_level    (wr_level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .sync_err    (sync_err)
    );

    always #5 wclk = ~wclk;

    int cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {S_GS, S_BS, S_LVL, S_AF, S_OVF, S_ERR, S_ZERO} sel_t;
    typedef struct {
        string name;
        int    at;
        sel_t  sel;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   mon_act;

    task automatic push_exp(input string nm, input sel_t s, input int v, input int dly);
        exp_t e;
        e.name = nm;
        e.at   = cyc + dly;
        e.sel  = s;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    function automatic logic [3:0] gray(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    // Monitor: check every expectation that is due on this cycle.
    always @(negedge wclk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                case (sbq[i].sel)
                    S_GS:    mon_act = int'(g_rptr_sync);
                    S_BS:    mon_act = int'(b_rptr_sync);
                    S_LVL:   mon_act = int'(wr_level);
                    S_AF:    mon_act = int'(almost_full);
                    S_OVF:   mon_act = int'(overflow);
                    S_ERR:   mon_act = int'(sync_err);
                    default: mon_act = int'({g_rptr_sync, b_rptr_sync, wr_level,
                                             almost_full, overflow, sync_err});
                endcase
                n_cmp++;
                if (sbq[i].at < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)",
                             sbq[i].name, sbq[i].at, cyc);
                end else if (mon_act != sbq[i].val) begin
                    n_bad++;
                    $display("FAIL %s at cyc %0d: got 0x%0h, want 0x%0h",
                             sbq[i].name, cyc, mon_act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b0; g_rptr = '0; b_wptr = '0;
        w_en = 1'b0; full = 1'b0; clr_sticky = 1'b0;
        step(2);
        wrst_n = 1'b1;

        // Reset: random traffic with overflow forced, then async reset mid-cycle
        w_en = 1'b1; full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            g_rptr = 4'($urandom);
            b_wptr = 4'($urandom);
            step(1);
        end
        push_exp("pre_rst_ovf", S_OVF, 1, 0);
        step(1);
        #1;
        wrst_n = 1'b0;
        g_rptr = '0; b_wptr = '0; w_en = 1'b0; full = 1'b0;
        push_exp("rst_async", S_ZERO, 0, 0);
        step(2);
        push_exp("rst_held", S_ZERO, 0, 0);
        wrst_n = 1'b1;
        push_exp("rst_rel1", S_ZERO, 0, 1);
        push_exp("rst_rel2", S_ZERO, 0, 2);
        step(3);

        // Sync and decode latency
        b_wptr = 4'd4;
        step(4);
        g_rptr = 4'b0001;
        push_exp("gs_lat0", S_GS, 0, 1);
        push_exp("gs_1",    S_GS, 1, 2);
        push_exp("bs_1",    S_BS, 1, 3);
        step(4);
        g_rptr = 4'b0011;
        push_exp("gs_3", S_GS, 3, 2);
        push_exp("bs_2", S_BS, 2, 3);
        step(4);
        g_rptr = 4'b0010;
        push_exp("gs_2",  S_GS,  2, 2);
        push_exp("bs_3",  S_BS,  3, 3);
        push_exp("lvl_1", S_LVL, 1, 4);
        step(4);

        // Level and almost-full around the threshold
        g_rptr = 4'b0000; b_wptr = 4'd6;
        push_exp("lvl_6", S_LVL, 6, 4);
        push_exp("af_6",  S_AF,  1, 4);
        step(5);
        g_rptr = 4'b0001;
        push_exp("lvl_5", S_LVL, 5, 4);
        push_exp("af_5",  S_AF,  0, 4);
        step(5);

        // Walk the read pointer to binary 12, keeping the writer just ahead
        for (int b = 2; b <= 12; b++) begin
            g_rptr = gray(b);
            b_wptr = 4'((b + 2) & 15);
            step(1);
        end
        step(5);
        push_exp("walk_bs12", S_BS, 12, 0);
        b_wptr = 4'b0010;
        push_exp("wrap_lvl6", S_LVL, 6, 1);
        push_exp("wrap_af",   S_AF,  1, 1);
        push_exp("walk_err0", S_ERR, 0, 1);
        step(2);

        // Walk on through the lap to read pointer 0, then a level of exactly DEPTH
        for (int b = 13; b <= 16; b++) begin
            g_rptr = gray(b & 15);
            b_wptr = 4'((b + 2) & 15);
            step(1);
        end
        step(5);
        b_wptr = 4'b1000;
        push_exp("lvl_depth", S_LVL, 8, 1);
        push_exp("af_depth",  S_AF,  1, 1);
        push_exp("err_depth", S_ERR, 0, 2);
        step(3);

        // Overflow: set, hold, clear, then set and clear on the same edge
        w_en = 1'b1; full = 1'b1;
        push_exp("ovf_set",  S_OVF, 1, 1);
        push_exp("ovf_hold", S_OVF, 1, 3);
        step(1);
        w_en = 1'b0; full = 1'b0;
        step(3);
        clr_sticky = 1'b1;
        push_exp("ovf_clr", S_OVF, 0, 1);
        step(1);
        clr_sticky = 1'b0;
        step(2);
        w_en = 1'b1; full = 1'b1; clr_sticky = 1'b1;
        push_exp("ovf_set_wins", S_OVF, 1, 1);
        step(1);
        w_en = 1'b0; full = 1'b0; clr_sticky = 1'b0;
        step(2);
        push_exp("err_quiet", S_ERR, 0, 0);
        clr_sticky = 1'b1;
        step(1);
        clr_sticky = 1'b0;
        step(2);

        // Integrity: two-bit Gray jump, then a level beyond DEPTH
        g_rptr = 4'b0011;
        push_exp("err_jump", S_ERR, 1, 4);
        step(6);
        g_rptr = 4'b0001;
        step(5);
        g_rptr = 4'b0000;
        step(5);
        clr_sticky = 1'b1;
        push_exp("err_clr", S_ERR, 0, 1);
        step(1);
        clr_sticky = 1'b0;
        step(2);
        b_wptr = 4'b1100;
        push_exp("lvl_12",     S_LVL, 12, 1);
        push_exp("err_level",  S_ERR, 1,  1);
        push_exp("err_sticky", S_ERR, 1,  3);
        step(5);

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rptr_wsync_decoder.md
# rptr_wsync_decoder

Write-clock-domain receiver for the Gray-coded read pointer of the async FIFO. Synchronizes `g_rptr` from the read domain into `wclk` and decodes it back to binary. Computes a registered write-side fill level and an almost-full flag, plus sticky overflow and pointer-integrity error flags. Sits beside the write pointer handler: it takes that block's binary write pointer and `full`, and drives the synchronized Gray read pointer that the handler uses for its full comparison.

## Interface
- `PTR_WIDTH`, default 3: address bits; pointers are PTR_WIDTH+1 bits; DEPTH = 2**PTR_WIDTH.
- `SYNC_STAGES`, default 2, minimum 2: flops in the CDC chain.
- `AFULL_THRESH`, default 6: `almost_full` asserts when level ≥ this value; legal range 1..DEPTH.

- `wclk` input, 1 bit: write clock.
- `wrst_n` input, 1 bit: reset, asynchronous, active-low.
- `g_rptr` input, PTR_WIDTH+1 bits: Gray read pointer, launched from a read-domain register.
- `b_wptr` input, PTR_WIDTH+1 bits: binary write pointer from the write pointer handler.
- `w_en` input, 1 bit: write request.
- `full` input, 1 bit: registered full flag from the write pointer handler.
- `clr_sticky` input, 1 bit: synchronous clear of `overflow` and `sync_err`.
- `g_rptr_sync` output, PTR_WIDTH+1 bits: last stage of the sync chain.
- `b_rptr_sync` output, PTR_WIDTH+1 bits: registered binary decode of `g_rptr_sync`.
- `wr_level` output, PTR_WIDTH+1 bits: registered fill count, range 0..DEPTH.
- `almost_full` output, 1 bit: registered.
- `overflow` output, 1 bit: sticky; a write was attempted while full.
- `sync_err` output, 1 bit: sticky; pointer integrity violation.

## Operation
- Sync chain: SYNC_STAGES flops clocked by `wclk`. Every flop is reset to 0. The chain carries no logic between stages. `g_rptr_sync` is the last stage.
- Decode: `b[MSB] = g[MSB]`; `b[i] = b[i+1] ^ g[i]` for i below MSB. The result is registered into `b_rptr_sync`.
- Level, computed each edge: `wr_level <= (b_wptr - b_rptr_sync)`, modulo 2**(PTR_WIDTH+1). `b_wptr` is sampled directly and `b_rptr_sync` is the registered value.
- Almost-full: `almost_full <= (level_next >= AFULL_THRESH)`, where level_next is the value being loaded into `wr_level`. It is therefore coincident with `wr_level`.
- Overflow: set on any edge where `w_en && full`. Cleared by `clr_sticky`. If set and clear occur on the same edge, set wins.
- Integrity check, `sync_err` is set when either condition holds:
  - consecutive `g_rptr_sync` values differ in more than 1 bit;
  - level_next > DEPTH.
- `sync_err` uses the same clear and priority rules as `overflow`.
- No state machine. All outputs are registered and there are no combinational paths from inputs to outputs.

## Timing
- Reset: all sync flops, `g_rptr_sync`, `b_rptr_sync`, `wr_level`, `almost_full`, `overflow` and `sync_err` are 0. Both domains are reset together at system level. Assertion mid-operation clears all state immediately, and the sticky flags are lost.
- `g_rptr` change → `g_rptr_sync`: SYNC_STAGES edges.
- `g_rptr_sync` → `b_rptr_sync`: +1 edge.
- `b_rptr_sync` or `b_wptr` change → `wr_level` / `almost_full`: +1 edge.
- Read-side lag makes `wr_level` overstate the true fill, which is safe. It never reports space that does not exist.
- Wrap-around: handled by modulo subtraction with the MSB as the lap bit. A level of DEPTH with MSBs differing is legal.
- Simultaneous `w_en && full` and `clr_sticky`: `overflow` is 1 after the edge.

## Structure
- Shared package `fifo_pkg` holds:
  - `gray2bin` and `bin2gray` functions, parameterized by width;
  - a `ptr_t` typedef convention;
  - a popcount-based `gray_step_ok` helper.
- Sub-module `sync_chain` (WIDTH, STAGES; clk, rst_n, d, q) is a reusable multi-flop synchronizer, also instantiated by the read-domain counterpart.
- Top file contains the decode register, level subtractor, flags, and the integrity checker.

## Test plan
All scenarios use PTR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6.
- Reset: drive random inputs, pulse `wrst_n` low mid-run → every output is 0 asynchronously, and stays 0 for 2 edges after release with `g_rptr`=0.
- Sync/decode: step `g_rptr` 0000→0001→0011→0010, holding each for 4 cycles → `g_rptr_sync` follows after 2 edges, and `b_rptr_sync` reads 1, 2, 3 one edge later.
- Level/almost-full: `b_wptr`=6 with read pointer 0 → `wr_level`=6 and `almost_full`=1. Advance the read pointer to 1 → `wr_level`=5 and `almost_full`=0.
- Wrap: `b_wptr`=0010 with `b_rptr_sync`=1100 → `wr_level`=6. `b_wptr`=1000 with read pointer 0 → `wr_level`=8 and `sync_err` stays 0.
- Overflow: `w_en`=1 and `full`=1 for one cycle → `overflow`=1 and held. Pulse `clr_sticky` → 0. Set and clear on the same edge → 1.
- Integrity: `g_rptr` jumps 0000→0011 → `sync_err`=1. After clearing it, `b_wptr`=1100 with read pointer 0 (level 12 > 8) → `sync_err`=1.
